deserializer_out: RTL and testbench

- Receive-side counterpart of the packet serializer.
- Takes the 1-bit serial line, one bit per clk_i, LSB-first, in 9-bit words {k, byte[7:0]}.
- Aligns to the comma K-code (k=1, 8'h3C), frames packets of the form COMMA, B0, B1, B2, COMMA, and presents the 3 payload bytes as a 32-bit word with a one-cycle valid strobe.
- Sits between the serial link input and the packet consumer; also reports lock and framing errors.

---
 rtl/deserializer_out.sv | 218 +++++++++++++++++++++
 tb/tb_deserializer_out.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/deserializer_out.sv
// -----------------------------------------------------------------------------
// deserializer_out
//
// Receive side of the packet serializer. The serial line carries 9-bit words
// {k, byte[7:0]}, LSB first. The block hunts for the comma K-code, confirms
// alignment over LOCK_CNT consecutive commas, then frames packets of the form
// COMMA, B0, B1, B2, COMMA. It delivers the payload on data_o with a one-cycle
// valid_o strobe.
//
// Ports:
//   clk_i    in   1   system clock, one serial bit per rising edge
//   rst_i    in   1   asynchronous active-low reset
//   data_i   in   1   serial line bit (word bit 0 first, k bit last)
//   data_o   out  32  {8'h00, B2, B1, B0} of the last good packet
//   valid_o  out  1   one-cycle pulse, data_o updated this cycle
//   ena_o    out  1   one-cycle strobe at each aligned word boundary
//   lock_o   out  1   high while aligned to the word stream
//   err_o    out  1   one-cycle pulse on a framing error
// -----------------------------------------------------------------------------
module deserializer_out #(
    parameter int unsigned LOCK_CNT = 2,
    parameter logic [7:0]  COMMA    = 8'h3C
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_i,
    output logic [31:0] data_o,
    output logic        valid_o,
    output logic        ena_o,
    output logic        lock_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        ST_HUNT   = 3'd0,
        ST_VERIFY = 3'd1,
        ST_ARMED  = 3'd2,
        ST_DATA   = 3'd3,
        ST_TRAIL  = 3'd4
    } state_t;

    localparam logic [2:0] LOCK_CNT_W = 3'(LOCK_CNT);
    localparam logic [8:0] K_COMMA    = {1'b1, COMMA};

    state_t      state_q, state_d;
    logic [8:0]  sr_q, sr_d;
    logic [3:0]  cnt_bit_q, cnt_bit_d;
    logic [2:0]  comma_cnt_q, comma_cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  b0_q, b0_d;
    logic [7:0]  b1_q, b1_d;
    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        ena_q, ena_d;
    logic        lock_q, lock_d;
    logic        err_q, err_d;

    // The word completed by the bit arriving on this edge.
    logic [8:0]  w_s;
    logic        is_comma_s;
    logic        is_k_s;
    logic        boundary_s;

    assign w_s        = {data_i, sr_q[8:1]};
    assign is_comma_s = (w_s == K_COMMA);
    assign is_k_s     = w_s[8];
    assign boundary_s = (cnt_bit_q == 4'd8);

    // Next-state, framing and output pulse computation.
    always_comb begin
        state_d     = state_q;
        sr_d        = w_s;
        cnt_bit_d   = boundary_s ? 4'd0 : (cnt_bit_q + 4'd1);
        comma_cnt_d = comma_cnt_q;
        idx_d       = idx_q;
        b0_d        = b0_q;
        b1_d        = b1_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;
        ena_d       = boundary_s && (state_q != ST_HUNT);

        case (state_q)
            ST_HUNT: begin
                // Any bit position may start a word; the comma defines alignment.
                if (is_comma_s) begin
                    cnt_bit_d   = 4'd0;
                    comma_cnt_d = 3'd1;
                    idx_d       = 2'd0;
                    state_d     = (LOCK_CNT_W == 3'd1) ? ST_ARMED : ST_VERIFY;
                end else begin
                    state_d = ST_HUNT;
                end
            end
            ST_VERIFY: begin
                if (boundary_s) begin
                    if (is_comma_s) begin
                        comma_cnt_d = comma_cnt_q + 3'd1;
                        if ((comma_cnt_q + 3'd1) == LOCK_CNT_W) begin
                            state_d = ST_ARMED;
                        end else begin
                            state_d = ST_VERIFY;
                        end
                    end else begin
                        // False alignment is not a framing error.
                        state_d = ST_HUNT;
                    end
                end else begin
                    state_d = ST_VERIFY;
                end
            end
            ST_ARMED: begin
                if (boundary_s) begin
                    if (is_comma_s) begin
                        state_d = ST_ARMED;
                    end else if (!is_k_s) begin
                        b0_d    = w_s[7:0];
                        idx_d   = 2'd1;
                        state_d = ST_DATA;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_HUNT;
                    end
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_DATA: begin
                if (boundary_s) begin
                    if (!is_k_s) begin
                        if (idx_q == 2'd1) begin
                            b1_d    = w_s[7:0];
                            idx_d   = 2'd2;
                            state_d = ST_DATA;
                        end else begin
                            // Third payload byte goes straight to the output word.
                            data_d  = {8'h00, w_s[7:0], b1_q, b0_q};
                            valid_d = 1'b1;
                            idx_d   = 2'd0;
                            state_d = ST_TRAIL;
                        end
                    end else if (is_comma_s) begin
                        // Truncated packet: alignment is still trustworthy.
                        err_d   = 1'b1;
                        idx_d   = 2'd0;
                        b0_d    = 8'h00;
                        b1_d    = 8'h00;
                        state_d = ST_ARMED;
                    end else begin
                        err_d   = 1'b1;
                        idx_d   = 2'd0;
                        b0_d    = 8'h00;
                        b1_d    = 8'h00;
                        state_d = ST_HUNT;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_TRAIL: begin
                if (boundary_s) begin
                    if (is_comma_s) begin
                        state_d = ST_ARMED;
                    end else begin
                        // Overlong packet or unexpected K-code; delivered data stands.
                        err_d   = 1'b1;
                        state_d = ST_HUNT;
                    end
                end else begin
                    state_d = ST_TRAIL;
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase

        lock_d = (state_d == ST_ARMED) || (state_d == ST_DATA) || (state_d == ST_TRAIL);
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_HUNT;
            sr_q        <= 9'd0;
            cnt_bit_q   <= 4'd0;
            comma_cnt_q <= 3'd0;
            idx_q       <= 2'd0;
            b0_q        <= 8'h00;
            b1_q        <= 8'h00;
            data_q      <= 32'd0;
            valid_q     <= 1'b0;
            ena_q       <= 1'b0;
            lock_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_bit_q   <= cnt_bit_d;
            comma_cnt_q <= comma_cnt_d;
            idx_q       <= idx_d;
            b0_q        <= b0_d;
            b1_q        <= b1_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            ena_q       <= ena_d;
            lock_q      <= lock_d;
            err_q       <= err_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign ena_o   = ena_q;
    assign lock_o  = lock_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_deserializer_out.sv
// -----------------------------------------------------------------------------
// tb_deserializer_out
//
// Drives a serial bit stream into deserializer_out and compares every output
// on every cycle against a word-level behavioural model, plus literal checks
// for the directed packet scenarios.
// -----------------------------------------------------------------------------
module tb_deserializer_out;

    localparam int         LOCK    = 2;
    localparam logic [8:0] K_COMMA = 9'h13C;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        data_i;
    logic [31:0] data_o;
    logic        valid_o;
    logic        ena_o;
    logic        lock_o;
    logic        err_o;

    always #5 clk_i = ~clk_i;

    deserializer_out #(.LOCK_CNT(LOCK), .COMMA(8'h3C)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .data_i  (data_i),
        .data_o  (data_o),
        .valid_o (valid_o),
        .ena_o   (ena_o),
        .lock_o  (lock_o),
        .err_o   (err_o)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Behavioural model: a 9-bit window, an alignment phase and a payload queue.
    logic [8:0]  m_win;
    bit          m_aligned;
    bit          m_lock;
    bit          m_delivered;
    int          m_pos;
    int          m_run;
    logic [7:0]  m_pay[$];
    logic [31:0] exp_data;
    logic        exp_valid, exp_ena, exp_lock, exp_err;

    // Observations of the DUT used by the directed literal checks.
    int          obs_valid;
    int          obs_err;
    logic [31:0] obs_data;
    bit          gap_en;
    int          last_ena;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void model_reset();
        m_win       = 9'd0;
        m_aligned   = 1'b0;
        m_lock      = 1'b0;
        m_delivered = 1'b0;
        m_pos       = 0;
        m_run       = 0;
        m_pay.delete();
        exp_data    = 32'd0;
        exp_valid   = 1'b0;
        exp_ena     = 1'b0;
        exp_lock    = 1'b0;
        exp_err     = 1'b0;
    endfunction

    function automatic void model_drop();
        m_aligned   = 1'b0;
        m_lock      = 1'b0;
        m_delivered = 1'b0;
        m_pay.delete();
    endfunction

    function automatic void model_word();
        bit comma;
        comma = (m_win == K_COMMA);
        if (!m_lock) begin
            if (comma) begin
                m_run++;
                if (m_run >= LOCK) m_lock = 1'b1;
            end else begin
                m_aligned = 1'b0;
            end
        end else if (comma) begin
            if (m_pay.size() != 0 && !m_delivered) exp_err = 1'b1;
            m_pay.delete();
            m_delivered = 1'b0;
        end else if (m_win[8] || m_delivered) begin
            exp_err = 1'b1;
            model_drop();
        end else begin
            m_pay.push_back(m_win[7:0]);
            if (m_pay.size() == 3) begin
                exp_data    = {8'h00, m_pay[2], m_pay[1], m_pay[0]};
                exp_valid   = 1'b1;
                m_delivered = 1'b1;
            end
        end
    endfunction

    function automatic void model_step(input logic b);
        m_win     = {b, m_win[8:1]};
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        exp_ena   = 1'b0;
        if (!m_aligned) begin
            if (m_win == K_COMMA) begin
                m_aligned   = 1'b1;
                m_pos       = 0;
                m_run       = 1;
                m_lock      = (LOCK == 1);
                m_delivered = 1'b0;
                m_pay.delete();
            end
        end else begin
            m_pos++;
            if (m_pos == 9) begin
                m_pos   = 0;
                exp_ena = 1'b1;
                model_word();
            end
        end
        exp_lock = m_lock;
    endfunction

    // Compare every output against the model; called on each falling edge.
    function automatic void check_outputs();
        chk("data_o",  data_o,  exp_data);
        chk("valid_o", {31'd0, valid_o}, {31'd0, exp_valid});
        chk("ena_o",   {31'd0, ena_o},   {31'd0, exp_ena});
        chk("lock_o",  {31'd0, lock_o},  {31'd0, exp_lock});
        chk("err_o",   {31'd0, err_o},   {31'd0, exp_err});
        chk("valid_err_excl", {31'd0, valid_o & err_o}, 32'd0);
        if (valid_o) begin
            obs_valid++;
            obs_data = data_o;
        end
        if (err_o) obs_err++;
        if (ena_o) begin
            if (gap_en && last_ena >= 0) chk("ena_gap", cyc - last_ena, 32'd9);
            last_ena = cyc;
        end
        cyc++;
    endfunction

    // Called at a falling edge: check, present the next bit, advance the model.
    task automatic send_bit(input logic b);
        check_outputs();
        data_i = b;
        model_step(b);
        @(negedge clk_i);
    endtask

    task automatic send_word(input logic [8:0] w);
        for (int i = 0; i < 9; i++) send_bit(w[i]);
    endtask

    task automatic send_commas(input int n);
        for (int i = 0; i < n; i++) send_word(K_COMMA);
    endtask

    task automatic clear_obs();
        obs_valid = 0;
        obs_err   = 0;
        obs_data  = 32'd0;
    endtask

    // Asynchronous reset applied at a falling edge, held through one rising edge.
    task automatic do_reset();
        rst_i = 1'b0;
        #1;
        chk("rst_data",  data_o, 32'd0);
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_ena",   {31'd0, ena_o},   32'd0);
        chk("rst_lock",  {31'd0, lock_o},  32'd0);
        chk("rst_err",   {31'd0, err_o},   32'd0);
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        clear_obs();
    endtask

    initial begin
        logic [4:0] garbage;
        int         r;
        int         nb;

        rst_i    = 1'b0;
        data_i   = 1'b0;
        gap_en   = 1'b0;
        last_ena = -1;
        model_reset();
        clear_obs();
        repeat (2) @(negedge clk_i);
        do_reset();

        // 1: lock on the second comma, one packet A5 5A C3.
        send_word(K_COMMA);
        chk("s1_lock_first", {31'd0, lock_o}, 32'd0);
        send_word(K_COMMA);
        chk("s1_lock_second", {31'd0, lock_o}, 32'd1);
        send_commas(2);
        send_word(9'h0A5);
        send_word(9'h05A);
        send_word(9'h0C3);
        send_word(K_COMMA);
        send_word(K_COMMA);
        chk("s1_valid_cnt", obs_valid, 32'd1);
        chk("s1_data", obs_data, 32'h00C35AA5);
        chk("s1_err_cnt", obs_err, 32'd0);

        // 2: same stream after 5 garbage bits, ena strobes 9 cycles apart.
        @(negedge clk_i);
        do_reset();
        garbage  = 5'b01101;
        last_ena = -1;
        gap_en   = 1'b1;
        for (int i = 0; i < 5; i++) send_bit(garbage[i]);
        send_commas(4);
        send_word(9'h0A5);
        send_word(9'h05A);
        send_word(9'h0C3);
        send_commas(2);
        gap_en = 1'b0;
        chk("s2_valid_cnt", obs_valid, 32'd1);
        chk("s2_data", obs_data, 32'h00C35AA5);
        chk("s2_lock", {31'd0, lock_o}, 32'd1);

        // 3: truncated packet, then a good one.
        clear_obs();
        send_word(K_COMMA);
        send_word(9'h011);
        send_word(9'h022);
        send_word(K_COMMA);
        send_word(K_COMMA);
        chk("s3_err_cnt", obs_err, 32'd1);
        chk("s3_valid_cnt", obs_valid, 32'd0);
        chk("s3_lock", {31'd0, lock_o}, 32'd1);
        send_word(9'h001);
        send_word(9'h002);
        send_word(9'h003);
        send_word(K_COMMA);
        send_word(K_COMMA);
        chk("s3_data", obs_data, 32'h00030201);

        // 4: overlong packet, error after delivery, relock after two commas.
        clear_obs();
        send_word(9'h010);
        send_word(9'h020);
        send_word(9'h030);
        send_word(9'h040);
        chk("s4_err", {31'd0, err_o}, 32'd1);
        chk("s4_unlock", {31'd0, lock_o}, 32'd0);
        send_commas(2);
        chk("s4_relock", {31'd0, lock_o}, 32'd1);
        chk("s4_valid_cnt", obs_valid, 32'd1);
        chk("s4_data", obs_data, 32'h00302010);
        chk("s4_err_cnt", obs_err, 32'd1);

        // 5: K-code that is not a comma while armed.
        send_word(9'h1F7);
        chk("s5_err", {31'd0, err_o}, 32'd1);
        chk("s5_unlock", {31'd0, lock_o}, 32'd0);
        send_commas(3);

        // 6: reset in the middle of B1, then a clean packet.
        send_word(9'h0A5);
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        do_reset();
        send_commas(3);
        send_word(9'h077);
        send_word(9'h088);
        send_word(9'h099);
        send_commas(2);
        chk("s6_valid_cnt", obs_valid, 32'd1);
        chk("s6_err_cnt", obs_err, 32'd0);
        chk("s6_data", obs_data, 32'h00998877);

        // 7: randomized traffic with packets, stray bytes, K-codes and bit slips.
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 40) begin
                send_word({1'b0, 8'($urandom)});
                send_word({1'b0, 8'($urandom)});
                send_word({1'b0, 8'($urandom)});
                send_word(K_COMMA);
            end else if (r < 70) begin
                send_word(K_COMMA);
            end else if (r < 85) begin
                send_word({1'b0, 8'($urandom)});
            end else if (r < 92) begin
                send_word({1'b1, 8'($urandom)});
            end else begin
                nb = int'($urandom_range(1, 8));
                for (int i = 0; i < nb; i++) send_bit(1'($urandom));
            end
        end
        send_commas(3);
        check_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
